// File: rtl/f_pc_redirect.sv
// Fetch PC unit: resolves jumps/branches in decode, owns the PC, flushes IF on a
// redirect and parks the redirect target while instruction memory is busy.
//
//   state  | meaning
//   S_RUN  | sequential fetch; redirects applied directly when imem is ready
//   S_PEND | redirect target parked in r_pend_pc until imem accepts it
module f_pc_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid_d,
  input  logic        i_stall,
  input  logic        i_imem_ready,
  input  logic [1:0]  i_jump,
  input  logic [2:0]  i_bop,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  input  logic [31:0] i_pc4_d,
  output logic [31:0] o_pc,
  output logic        o_flush,
  output logic        o_taken,
  output logic        o_pend
);

  typedef enum logic {S_RUN, S_PEND} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_pend_pc, w_pend_pc_nxt;

  logic        w_rs_zero, w_rs_neg, w_br_true, w_redir;
  logic [31:0] w_br_off, w_br_tgt, w_j_tgt, w_target;

  assign w_rs_zero = (i_rs_data == 32'h0);
  assign w_rs_neg  = i_rs_data[31];

  always_comb begin
    w_br_true = 1'b0;
    if (i_jump == 2'b00) begin
      unique case (i_bop)
        3'b001:  w_br_true = (i_rs_data == i_rt_data);
        3'b010:  w_br_true = (i_rs_data != i_rt_data);
        3'b011:  w_br_true = w_rs_neg | w_rs_zero;
        3'b100:  w_br_true = ~w_rs_neg & ~w_rs_zero;
        3'b101:  w_br_true = w_rs_neg;
        3'b110:  w_br_true = ~w_rs_neg;
        default: w_br_true = 1'b0;
      endcase
    end
  end

  assign w_redir  = i_valid_d & ~i_stall &
                    ((i_jump == 2'b01) | (i_jump == 2'b10) | w_br_true);
  assign w_br_off = {{14{i_imm[15]}}, i_imm, 2'b00};
  assign w_br_tgt = i_pc4_d + w_br_off;
  assign w_j_tgt  = {i_pc4_d[31:28], i_target, 2'b00};

  always_comb begin
    w_target = w_br_tgt;
    if (i_jump == 2'b01)      w_target = w_j_tgt;
    else if (i_jump == 2'b10) w_target = i_rs_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_RUN;
      r_pc      <= RESET_PC;
      r_pend_pc <= 32'h0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pend_pc <= w_pend_pc_nxt;
    end
  end

  // Priority: redirect > parked target > sequential increment > hold.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pend_pc_nxt = r_pend_pc;
    unique case (r_state)
      S_RUN: begin
        if (w_redir && i_imem_ready) begin
          w_pc_nxt = w_target;
        end else if (w_redir) begin
          w_pend_pc_nxt = w_target;
          w_state_nxt   = S_PEND;
        end else if (i_imem_ready && !i_stall) begin
          w_pc_nxt = r_pc + 32'd4;
        end
      end
      S_PEND: begin
        if (w_redir && i_imem_ready) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_RUN;
        end else if (w_redir) begin
          w_pend_pc_nxt = w_target;
        end else if (i_imem_ready) begin
          w_pc_nxt    = r_pend_pc;
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign o_pc    = r_pc;
  assign o_pend  = (r_state == S_PEND);
  // Redirect strobes are combinational, so gate them directly by reset.
  assign o_flush = w_redir & i_rst_n;
  assign o_taken = w_redir & i_rst_n;

endmodule

// File: tb/tb_f_pc_redirect.sv
// Directed bench for f_pc_redirect: expected next-PC values queued at drive time
// and popped after the clock edge; combinational strobes checked before the edge.
module tb_f_pc_redirect;

  logic        i_clk, i_rst_n, i_valid_d, i_stall, i_imem_ready;
  logic [1:0]  i_jump;
  logic [2:0]  i_bop;
  logic [31:0] i_rs_data, i_rt_data, i_pc4_d;
  logic [15:0] i_imm;
  logic [25:0] i_target;
  logic [31:0] o_pc;
  logic        o_flush, o_taken, o_pend;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;
  logic [31:0] exp_q[$];

  f_pc_redirect #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid_d(i_valid_d), .i_stall(i_stall),
    .i_imem_ready(i_imem_ready), .i_jump(i_jump), .i_bop(i_bop),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
    .i_target(i_target), .i_pc4_d(i_pc4_d), .o_pc(o_pc), .o_flush(o_flush),
    .o_taken(o_taken), .o_pend(o_pend)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already driven.
  task automatic step(input string tag, input logic ef, input logic ep,
                      input logic [31:0] enext);
    logic [31:0] e;
    #1;
    chk({tag, "_flush"}, {31'h0, o_flush}, {31'h0, ef});
    chk({tag, "_taken"}, {31'h0, o_taken}, {31'h0, ef});
    chk({tag, "_pend"},  {31'h0, o_pend},  {31'h0, ep});
    chk({tag, "_pc"},    o_pc, m_pc);
    exp_q.push_back(enext);
    @(posedge i_clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_next"}, o_pc, e);
    m_pc = e;
    @(negedge i_clk);
  endtask

  task automatic drv(input logic v, input logic s, input logic rdy, input logic [1:0] j,
                     input logic [2:0] b, input logic [31:0] rs, input logic [31:0] rt,
                     input logic [15:0] imm, input logic [31:0] pc4);
    i_valid_d = v; i_stall = s; i_imem_ready = rdy; i_jump = j; i_bop = b;
    i_rs_data = rs; i_rt_data = rt; i_imm = imm; i_pc4_d = pc4;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_target = 26'h0000040;
    drv(1'b1, 1'b0, 1'b1, 2'b01, 3'b000, 32'h0, 32'h0, 16'h0, 32'hA000_0010);
    #1;
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_pend", {31'h0, o_pend}, 32'h0);
    chk("rst_flush", {31'h0, o_flush}, 32'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    drv(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 32'h0, 32'h0, 16'h0, 32'h0);
    i_rst_n = 1'b1;
    m_pc = 32'h0;
    step("seq0", 1'b0, 1'b0, 32'h4);
    step("seq1", 1'b0, 1'b0, 32'h8);
    step("seq2", 1'b0, 1'b0, 32'hC);
    step("seq3", 1'b0, 1'b0, 32'h10);

    drv(1'b1, 1'b0, 1'b1, 2'b00, 3'b001, 32'h5, 32'h5, 16'hFFFE, 32'h104);
    step("beq_t", 1'b1, 1'b0, 32'hFC);
    i_rt_data = 32'h6;
    step("beq_nt", 1'b0, 1'b0, 32'h100);

    drv(1'b1, 1'b0, 1'b1, 2'b00, 3'b011, 32'hFFFF_FFFF, 32'h0, 16'h0004, 32'h200);
    step("blez_m1", 1'b1, 1'b0, 32'h210);
    i_bop = 3'b101; i_imm = 16'h0008;
    step("bltz_m1", 1'b1, 1'b0, 32'h220);
    i_bop = 3'b100;
    step("bgtz_m1", 1'b0, 1'b0, 32'h224);
    i_bop = 3'b110;
    step("bgez_m1", 1'b0, 1'b0, 32'h228);
    drv(1'b1, 1'b0, 1'b1, 2'b00, 3'b011, 32'h0, 32'h0, 16'h0004, 32'h200);
    step("blez_0", 1'b1, 1'b0, 32'h210);
    i_bop = 3'b110; i_imm = 16'h0008;
    step("bgez_0", 1'b1, 1'b0, 32'h220);
    i_bop = 3'b100;
    step("bgtz_0", 1'b0, 1'b0, 32'h224);
    i_bop = 3'b101;
    step("bltz_0", 1'b0, 1'b0, 32'h228);
    i_bop = 3'b000;
    step("bop0", 1'b0, 1'b0, 32'h22C);
    i_bop = 3'b111;
    step("bop7", 1'b0, 1'b0, 32'h230);

    drv(1'b1, 1'b0, 1'b1, 2'b01, 3'b000, 32'h0, 32'h0, 16'h0, 32'hA000_0010);
    step("j", 1'b1, 1'b0, 32'hA000_0100);
    drv(1'b1, 1'b0, 1'b1, 2'b10, 3'b000, 32'h0000_2004, 32'h0, 16'h0, 32'h0);
    step("jr", 1'b1, 1'b0, 32'h0000_2004);
    drv(1'b1, 1'b0, 1'b1, 2'b11, 3'b001, 32'h7, 32'h7, 16'h0010, 32'h0);
    step("j11", 1'b0, 1'b0, 32'h2008);

    drv(1'b1, 1'b0, 1'b0, 2'b01, 3'b000, 32'h0, 32'h0, 16'h0, 32'hA000_0010);
    step("pend0", 1'b1, 1'b0, 32'h2008);
    i_valid_d = 1'b0;
    step("pend1", 1'b0, 1'b1, 32'h2008);
    step("pend2", 1'b0, 1'b1, 32'h2008);
    i_imem_ready = 1'b1;
    step("pend_go", 1'b0, 1'b1, 32'hA000_0100);
    step("pend_done", 1'b0, 1'b0, 32'hA000_0104);

    drv(1'b1, 1'b1, 1'b1, 2'b00, 3'b001, 32'h5, 32'h5, 16'hFFFE, 32'h104);
    step("stall_beq", 1'b0, 1'b0, 32'hA000_0104);
    drv(1'b1, 1'b0, 1'b0, 2'b10, 3'b000, 32'h3000, 32'h0, 16'h0, 32'h0);
    step("stp_enter", 1'b1, 1'b0, 32'hA000_0104);
    drv(1'b1, 1'b1, 1'b1, 2'b10, 3'b000, 32'h3400, 32'h0, 16'h0, 32'h0);
    step("stp_apply", 1'b0, 1'b1, 32'h3000);
    drv(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 32'h0, 32'h0, 16'h0, 32'h0);
    step("stp_seq", 1'b0, 1'b0, 32'h3004);

    drv(1'b1, 1'b0, 1'b0, 2'b10, 3'b000, 32'h4000, 32'h0, 16'h0, 32'h0);
    step("nw_enter", 1'b1, 1'b0, 32'h3004);
    i_rs_data = 32'h5000;
    step("nw_over", 1'b1, 1'b1, 32'h3004);
    i_valid_d = 1'b0; i_imem_ready = 1'b1;
    step("nw_apply", 1'b0, 1'b1, 32'h5000);
    drv(1'b1, 1'b0, 1'b0, 2'b10, 3'b000, 32'h6000, 32'h0, 16'h0, 32'h0);
    step("pr_enter", 1'b1, 1'b0, 32'h5000);
    drv(1'b1, 1'b0, 1'b1, 2'b10, 3'b000, 32'h7000, 32'h0, 16'h0, 32'h0);
    step("pr_redir", 1'b1, 1'b1, 32'h7000);
    i_valid_d = 1'b0;
    step("pr_seq", 1'b0, 1'b0, 32'h7004);

    drv(1'b1, 1'b0, 1'b1, 2'b10, 3'b000, 32'hFFFF_FFFC, 32'h0, 16'h0, 32'h0);
    step("wrap_jr", 1'b1, 1'b0, 32'hFFFF_FFFC);
    i_valid_d = 1'b0;
    step("wrap_seq", 1'b0, 1'b0, 32'h0);
    drv(1'b1, 1'b0, 1'b1, 2'b00, 3'b001, 32'h1, 32'h1, 16'h8000, 32'h4);
    step("br_wrap", 1'b1, 1'b0, 32'hFFFE_0004);

    drv(1'b1, 1'b0, 1'b0, 2'b01, 3'b000, 32'h0, 32'h0, 16'h0, 32'hA000_0010);
    step("rp_enter", 1'b1, 1'b0, 32'hFFFE_0004);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rp_pc", o_pc, 32'h0);
    chk("rp_pend", {31'h0, o_pend}, 32'h0);
    chk("rp_flush", {31'h0, o_flush}, 32'h0);
    chk("rp_taken", {31'h0, o_taken}, 32'h0);
    @(negedge i_clk);
    drv(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 32'h0, 32'h0, 16'h0, 32'h0);
    i_rst_n = 1'b1;
    m_pc = 32'h0;
    step("rp_seq0", 1'b0, 1'b0, 32'h4);
    step("rp_seq1", 1'b0, 1'b0, 32'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/f_pc_redirect.md
# f_pc_redirect

Fetch-side program-counter unit for the MIPS pipeline. It consumes the decode-stage jump/branch controls (jump select, branch op) with the register operands and instruction fields, and resolves taken/not-taken in decode. It owns the PC register, issues a one-cycle flush of the fetched instruction on every redirect, and holds a redirect target pending while instruction memory is not ready.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- i_clk  input  1  clock, all state updates on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_valid_d  input  1  decode holds a valid instruction
- i_stall  input  1  hazard stall; freezes sequential fetch and blocks redirects
- i_imem_ready  input  1  instruction memory accepts o_pc this cycle
- i_jump  input  2  00 sequential/branch, 01 j/jal, 10 jr, 11 sequential (other R-type)
- i_bop  input  3  000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 111 none
- i_rs_data  input  32  forwarded rs value
- i_rt_data  input  32  forwarded rt value
- i_imm  input  16  branch offset field
- i_target  input  26  jump index field
- i_pc4_d  input  32  PC+4 of the decode instruction
- o_pc  output  32  fetch address
- o_flush  output  1  kill the instruction currently in IF (squash IF/ID write)
- o_taken  output  1  decode instruction redirects control
- o_pend  output  1  redirect target waiting for i_imem_ready

## Operation
- Redirect condition: redir = i_valid_d & ~i_stall & (i_jump==01 | i_jump==10 | branch_true).
- branch_true (only when i_jump==00): beq rs==rt; bne rs!=rt; blez rs signed <=0; bgtz signed >0; bltz rs[31]; bgez ~rs[31]; 000/111 false.
- Targets: branch = i_pc4_d + ({{14{i_imm[15]}}, i_imm, 2'b00}), 32-bit wrap-around; j = {i_pc4_d[31:28], i_target, 2'b00}; jr = i_rs_data unmodified (no alignment check).
- No delay slot: o_flush = redir, o_taken = redir (combinational, same cycle as decision).
- State machine, two states:
  - RUN: redir & i_imem_ready -> o_pc <= target, stay RUN. redir & ~i_imem_ready -> pend_pc <= target, go PEND. ~redir & i_imem_ready & ~i_stall -> o_pc <= o_pc + 4 (wraps at 2^32). Otherwise hold.
  - PEND: o_pend=1, o_pc held. New redir overrides pend_pc (newest wins); if i_imem_ready in same cycle, o_pc <= new target, go RUN. Else i_imem_ready -> o_pc <= pend_pc, go RUN, regardless of i_stall.
- Priority each cycle: redir > pending > sequential increment > hold.
- Reset (async, any state): o_pc=RESET_PC, pend_pc=0, state RUN; o_pend=0; o_flush and o_taken forced 0 while i_rst_n=0.

## Timing
- Decision to o_pc update: 1 edge when i_imem_ready; held until first edge with i_imem_ready otherwise.
- Taken redirect costs exactly one flushed fetch slot when memory ready.
- o_flush asserted only in redir cycle; never in PEND-only cycles.
- i_stall high: no redirect, no increment; PEND still completes.
- Reset deasserted mid-PEND: pending target discarded, fetch restarts at RESET_PC.

## Test plan
- Reset: assert i_rst_n=0 mid-run -> o_pc=32'h0 immediately, o_pend=0, o_flush=0; release with i_imem_ready=1 -> o_pc 0,4,8,C.
- beq taken: i_pc4_d=32'h104, imm=16'hFFFE, rs=rt=5 -> o_flush=o_taken=1 that cycle, next o_pc=32'h0FC; rs=5,rt=6 -> no flush, o_pc+4.
- Signed branches: rs=32'hFFFF_FFFF with blez/bltz -> taken; bgtz/bgez -> not taken; rs=0: blez/bgez taken, bgtz/bltz not.
- j/jr: i_pc4_d=32'hA000_0010, i_target=26'h0000040 -> o_pc=32'hA000_0100; jr rs=32'h0000_2004 -> o_pc=32'h0000_2004; i_jump=11 -> no redirect.
- Pending: jump with i_imem_ready=0 for 3 cycles -> o_pend=1, o_pc held, o_flush only first cycle; ready=1 -> o_pc=target, o_pend=0.
- Stall interplay: i_stall=1 with taken beq and i_valid_d=1 -> no flush, o_pc held; i_stall=1 in PEND with ready=1 -> pending applied.
